seq_restoring_divider: RTL

Multi-cycle unsigned integer divider: Quotient = Dividend / Divisor, Remainder = Dividend % Divisor.
It computes one quotient bit per clock, using a borrow-look-ahead subtractor as the trial-subtract datapath.
It is the inverse arithmetic counterpart to the structural look-ahead adders in the arithmetic library.
It sits behind a start/done handshake and is driven by a simple controller or testbench.

---
 rtl/arith_pkg.sv | 12 +
 rtl/struct_borrow_look_ahead_subtractor.sv | 46 ++++
 rtl/seq_restoring_divider.sv | 114 +++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: divider FSM state encoding and default width.
package arith_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/struct_borrow_look_ahead_subtractor.sv
// Borrow-look-ahead subtractor: D = X - Y - Bin, every borrow expanded
// directly from the per-bit generate/propagate terms, not rippled.
module struct_borrow_look_ahead_subtractor #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  logic [WIDTH-1:0] gb;
  logic [WIDTH-1:0] pb;
  logic [WIDTH:0]   b;

  // Per-bit borrow generate (0 - 1) and propagate (equal bits pass the borrow).
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_gp
    assign gb[gi] = ~x[gi] & y[gi];
    assign pb[gi] = ~(x[gi] ^ y[gi]);
  end

  // Look-ahead: borrow into bit i+1 is an OR of generates gated by all
  // propagates above them, plus Bin gated by the full propagate run.
  always_comb begin
    logic prop;
    logic acc;
    b    = '0;
    b[0] = bin;
    prop = 1'b1;
    acc  = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      prop = 1'b1;
      acc  = 1'b0;
      for (int j = i; j >= 0; j--) begin
        acc  = acc | (prop & gb[j]);
        prop = prop & pb[j];
      end
      b[i+1] = acc | (prop & bin);
    end
  end

  assign d    = x ^ y ^ b[WIDTH-1:0];
  assign bout = b[WIDTH];

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: one quotient bit per clock, trial subtraction
// done by the borrow-look-ahead subtractor. Results are registered and held.
module seq_restoring_divider
  import arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q_sr;      // dividend bits shift out the top, quotient bits in the bottom
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   rem;       // partial remainder R
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             bout;
  logic [CW-1:0]    cnt;
  logic             accept;

  assign accept = (state == IDLE) && start;

  // R shifted left with the next dividend bit entering at the bottom.
  assign rem_sh = (rem << 1) | {{WIDTH{1'b0}}, q_sr[WIDTH-1]};

  struct_borrow_look_ahead_subtractor #(
    .WIDTH (WIDTH + 1)
  ) u_sub (
    .x    (rem_sh),
    .y    ({1'b0, dvs}),
    .bin  (1'b0),
    .d    (diff),
    .bout (bout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: zero divisor skips CALC entirely.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (Divisor == '0) ? DONE : CALC;
      CALC:    if (cnt == CW'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state == CALC) || (state == DONE);
  end

  // Operand capture and one restoring step per CALC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_sr <= '0;
      dvd  <= '0;
      dvs  <= '0;
      rem  <= '0;
      cnt  <= '0;
    end else if (accept) begin
      q_sr <= Dividend;
      dvd  <= Dividend;
      dvs  <= Divisor;
      rem  <= '0;
      cnt  <= CW'(WIDTH);
    end else if (state == CALC) begin
      rem  <= bout ? rem_sh : diff;
      q_sr <= {q_sr[WIDTH-2:0], ~bout};
      cnt  <= cnt - CW'(1);
    end
  end

  // Result registers: loaded leaving DONE, held in IDLE until the next result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Quotient    <= '0;
      Remainder   <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= (state == DONE);
      if (accept) div_by_zero <= 1'b0;
      if (state == DONE) begin
        if (dvs == '0) begin
          Quotient    <= '1;
          Remainder   <= dvd;
          div_by_zero <= 1'b1;
        end else begin
          Quotient    <= q_sr;
          Remainder   <= rem[WIDTH-1:0];
        end
      end
    end
  end

endmodule
